iommu_ctx_cache: RTL

IOMMU_CTX_CACHE -- requirements
Module: iommu_ctx_cache

---
 rtl/iommu_ctx_cache.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/iommu_ctx_cache.sv
// iommu_ctx_cache: fully-associative IOMMU context cache keyed by {pv, did, pid}.
// One-cycle lookup response, single-cycle flush, tree-PLRU replacement.
// Optional hit/miss counters are enabled by defining IOMMU_CTXC_PERF_CNT_EN;
// without it the counter ports read 0 and cnt_clr_i has no effect.
module iommu_ctx_cache #(
  parameter int ENTRIES = 8,
  parameter int DID_W   = 24,
  parameter int PID_W   = 20,
  parameter int DATA_W  = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              flush_dv_i,
  input  logic              flush_pv_i,
  input  logic [DID_W-1:0]  flush_did_i,
  input  logic [PID_W-1:0]  flush_pid_i,
  input  logic              up_valid_i,
  input  logic              up_pv_i,
  input  logic [DID_W-1:0]  up_did_i,
  input  logic [PID_W-1:0]  up_pid_i,
  input  logic              up_v_i,
  input  logic [DATA_W-1:0] up_content_i,
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic              lu_pv_i,
  input  logic [DID_W-1:0]  lu_did_i,
  input  logic [PID_W-1:0]  lu_pid_i,
  output logic              rsp_valid_o,
  output logic              rsp_hit_o,
  output logic [DATA_W-1:0] rsp_content_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  input  logic              cnt_clr_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Tag and payload storage
  logic              r_valid [ENTRIES];
  logic              r_pv    [ENTRIES];
  logic [DID_W-1:0]  r_did   [ENTRIES];
  logic [PID_W-1:0]  r_pid   [ENTRIES];
  logic [DATA_W-1:0] r_data  [ENTRIES];
  // Tree-PLRU: node n has children 2n+1 / 2n+2; bit=1 means the victim lies right
  logic [ENTRIES-2:0] r_plru;

  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic [DATA_W-1:0] r_rsp_content;

  logic               w_lu_acc, w_up_en, w_touch_en;
  logic [ENTRIES-1:0] w_lu_match, w_up_match, w_flush_hit;
  logic               w_lu_hit, w_up_hit, w_free_any;
  logic [IDX_W-1:0]   w_lu_idx, w_up_idx, w_free_idx, w_victim, w_tgt_idx, w_touch_idx;
  logic [PID_W-1:0]   w_up_pid;
  logic [ENTRIES-2:0] w_plru_next;

  // A flush owns the cycle: lookups stall and updates are discarded.
  assign lu_ready_o = ~flush_i;
  assign w_lu_acc   = lu_valid_i & ~flush_i;
  assign w_up_en    = up_valid_i & up_v_i & ~flush_i;
  assign w_up_pid   = up_pv_i ? up_pid_i : '0;

  // Per-entry comparators for lookup, update and flush against the registered tags.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign w_lu_match[gi] = r_valid[gi] && (r_did[gi] == lu_did_i) && (r_pv[gi] == lu_pv_i)
                              && (!lu_pv_i || (r_pid[gi] == lu_pid_i));
      assign w_up_match[gi] = r_valid[gi] && (r_did[gi] == up_did_i) && (r_pv[gi] == up_pv_i)
                              && (!up_pv_i || (r_pid[gi] == up_pid_i));
      assign w_flush_hit[gi] = flush_i &&
                               (flush_pv_i ? ((r_did[gi] == flush_did_i) && (r_pid[gi] == flush_pid_i))
                                           : (!flush_dv_i || (r_did[gi] == flush_did_i)));
    end
  endgenerate

  // Lowest-index encoders for lookup hit, update hit and first free slot.
  always_comb begin
    w_lu_hit   = 1'b0;
    w_lu_idx   = '0;
    w_up_hit   = 1'b0;
    w_up_idx   = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_lu_match[i]) begin
        w_lu_hit = 1'b1;
        w_lu_idx = IDX_W'(i);
      end
      if (w_up_match[i]) begin
        w_up_hit = 1'b1;
        w_up_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Walk the PLRU tree from the root to find the replacement victim.
  always_comb begin : p_victim
    logic [IDX_W-1:0] node;
    node     = '0;
    w_victim = '0;
    for (int l = 0; l < IDX_W; l++) begin
      w_victim[IDX_W-1-l] = r_plru[node];
      node = IDX_W'(2 * node + 1 + r_plru[node]);
    end
  end

  // Existing tag is rewritten in place; otherwise first free slot, else PLRU victim.
  assign w_tgt_idx   = w_up_hit ? w_up_idx : (w_free_any ? w_free_idx : w_victim);
  // An update write takes the MRU slot over a same-cycle lookup hit.
  assign w_touch_en  = w_up_en | (w_lu_acc & w_lu_hit);
  assign w_touch_idx = w_up_en ? w_tgt_idx : w_lu_idx;

  // Point every node on the touched entry's path away from it.
  always_comb begin : p_plru_next
    logic [IDX_W-1:0] node;
    logic             dir;
    node        = '0;
    dir         = 1'b0;
    w_plru_next = r_plru;
    if (w_touch_en) begin
      for (int l = 0; l < IDX_W; l++) begin
        dir               = w_touch_idx[IDX_W-1-l];
        w_plru_next[node] = ~dir;
        node              = IDX_W'(2 * node + 1 + dir);
      end
    end
  end

  // Tag/payload array: flush invalidates matches, an update writes the target slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_pv[i]    <= 1'b0;
        r_did[i]   <= '0;
        r_pid[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_flush_hit[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_up_en && (w_tgt_idx == IDX_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_pv[i]    <= up_pv_i;
          r_did[i]   <= up_did_i;
          r_pid[i]   <= w_up_pid;
          r_data[i]  <= up_content_i;
        end
      end
    end
  end

  // PLRU state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_plru <= '0;
    else         r_plru <= w_plru_next;
  end

  // Registered lookup response, evaluated against the accept-cycle tags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_content <= '0;
    end else begin
      r_rsp_valid   <= w_lu_acc;
      r_rsp_hit     <= w_lu_acc & w_lu_hit;
      r_rsp_content <= (w_lu_acc && w_lu_hit) ? r_data[w_lu_idx] : '0;
    end
  end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_hit_o     = r_rsp_hit;
  assign rsp_content_o = r_rsp_content;

`ifdef IOMMU_CTXC_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Saturating hit/miss counters, bumped in the response cycle; clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_rsp_valid) begin
      if (r_rsp_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr_i;
  assign hit_cnt_o        = '0;
  assign miss_cnt_o       = '0;
`endif

endmodule
